ro_freq_meter: RTL and testbench

Gated frequency counter that sits directly downstream of the ring-oscillator block. It drives that block's `ro_activate` input and consumes its `ro_out` output. For a programmable window of `clk` cycles it counts rising edges of the oscillator, moves the count safely into the `clk` domain, and reports it with a one-cycle `done` pulse. The result is the raw entropy and frequency figure read by the controller.

---
 rtl/ro_pkg.sv | 36 +++
 rtl/ro_gray_counter.sv | 32 +++
 rtl/ro_freq_meter.sv | 168 ++++++++++++++++
 tb/tb_ro_freq_meter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared definitions for the ring-oscillator frequency meter.
// Holds the measurement FSM state type, default timing constants and
// Gray<->binary helpers used on both sides of the clock-domain crossing.
`timescale 1ns/1ps
package ro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } ro_meas_state_t;

  // Oscillator warm-up time in clk cycles before the window opens.
  localparam int RO_SETTLE_CYC_DEF  = 4;
  // Synchronizer depth for each Gray bit crossing into clk.
  localparam int RO_SYNC_STAGES_DEF = 2;
  // Working width of the conversion helpers; callers cast to their width.
  localparam int RO_GRAY_FN_W       = 32;

  function automatic logic [RO_GRAY_FN_W-1:0] bin2gray(input logic [RO_GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Unused upper bits are zero, so they convert to zero and do not disturb
  // the low-order result.
  function automatic logic [RO_GRAY_FN_W-1:0] gray2bin(input logic [RO_GRAY_FN_W-1:0] g);
    logic [RO_GRAY_FN_W-1:0] b;
    b[RO_GRAY_FN_W-1] = g[RO_GRAY_FN_W-1];
    for (int i = RO_GRAY_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ro_gray_counter.sv
// Oscillator-domain edge counter with a Gray-coded registered output.
// Latency: gray output changes one ro_clk rising edge after each count.
// No backpressure: free-running whenever the oscillator toggles.
`timescale 1ns/1ps
module ro_gray_counter
  import ro_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         ro_clk,
  input  logic         rst_n,
  output logic [W-1:0] gray
);

  logic [W-1:0] bin;
  logic [W-1:0] bin_nxt;

  assign bin_nxt = bin + W'(1);

  // Count oscillator edges; the Gray copy is a flop so only one bit ever
  // toggles per edge, which is what makes it safe to sample from clk.
  always_ff @(posedge ro_clk or posedge rst_n) begin
    if (rst_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_nxt;
      gray <= W'(bin2gray(RO_GRAY_FN_W'(bin_nxt)));
    end
  end

endmodule

// File: rtl/ro_freq_meter.sv
// Gated frequency meter: counts ro_in rising edges over win_len clk cycles.
// Latency: done pulses SETTLE_CYC + win_len + 1 cycles after start is taken.
// No backpressure: start is only honoured in IDLE; RO_FREQ_SAT_EN enables saturation.
`timescale 1ns/1ps
module ro_freq_meter
  import ro_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int DELTA_W     = 6,
  parameter int SYNC_STAGES = RO_SYNC_STAGES_DEF,
  parameter int SETTLE_CYC  = RO_SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_in,
  output logic             ro_activate,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // A single-flop synchronizer is never acceptable; a zero-length settle
  // would leave no time for the synchronizer to fill after activation.
  localparam int SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int SETTLE_N = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int SET_W    = $clog2(SETTLE_N + 1);
  localparam int SUM_W    = CNT_W + 1;

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_N - 1);
  localparam logic [SUM_W-1:0] SAT_VAL  = {1'b1, {CNT_W{1'b1}}};
  localparam logic [SUM_W-1:0] WRAP_MSK = {1'b0, {CNT_W{1'b1}}};

  logic [DELTA_W-1:0] ro_gray;
  logic [DELTA_W-1:0] sync_q [SYNC_N];
  logic [DELTA_W-1:0] g_now;
  logic [DELTA_W-1:0] g_prev;
  logic [DELTA_W-1:0] delta;

  ro_meas_state_t     state;
  logic [SET_W-1:0]   settle_cnt;
  logic [WIN_W-1:0]   win_r;
  logic [WIN_W-1:0]   win_cnt;
  logic [SUM_W-1:0]   acc;       // MSB is the sticky overflow flag
  logic [SUM_W-1:0]   acc_sum;
  logic [SUM_W-1:0]   acc_next;

  ro_gray_counter #(
    .W (DELTA_W)
  ) u_gray (
    .ro_clk (ro_in),
    .rst_n  (rst_n),
    .gray   (ro_gray)
  );

  // Bring each Gray bit into clk through a plain flop chain.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < SYNC_N; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= ro_gray;
      for (int i = 1; i < SYNC_N; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_now = DELTA_W'(gray2bin(RO_GRAY_FN_W'(sync_q[SYNC_N-1])));
  // Modulo subtraction absorbs counter wrap as long as fewer than
  // 2^DELTA_W - 1 edges arrive per clk cycle.
  assign delta = g_now - g_prev;

  // Remember last cycle's synchronized count so delta is edges-per-cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      g_prev <= '0;
    end else begin
      g_prev <= g_now;
    end
  end

  // Next accumulator value: clamp at all-ones with the flag set, or wrap.
  always_comb begin
    acc_sum  = '0;
    acc_next = '0;
`ifdef RO_FREQ_SAT_EN
    acc_sum  = {1'b0, acc[CNT_W-1:0]} + SUM_W'(delta);
    acc_next = (acc[CNT_W] | acc_sum[CNT_W]) ? SAT_VAL : acc_sum;
`else
    acc_sum  = acc + SUM_W'(delta);
    acc_next = acc_sum & WRAP_MSK;
`endif
  end

  // Measurement sequencer; all outputs are registered here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      win_r       <= '0;
      win_cnt     <= '0;
      acc         <= '0;
      ro_activate <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SETTLE;
            win_r       <= win_len;
            acc         <= '0;
            settle_cnt  <= '0;
            ro_activate <= 1'b1;
            busy        <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            if (win_r == '0) begin
              // Empty window: report the freshly cleared accumulator.
              state       <= DONE;
              ro_activate <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              count       <= acc[CNT_W-1:0];
              overflow    <= acc[CNT_W];
            end else begin
              state   <= MEASURE;
              win_cnt <= win_r;
            end
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        MEASURE: begin
          acc     <= acc_next;
          win_cnt <= win_cnt - WIN_W'(1);
          if (win_cnt == WIN_W'(1)) begin
            // Publish including this final cycle's delta so count is
            // already valid while done is high.
            state       <= DONE;
            ro_activate <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            count       <= acc_next[CNT_W-1:0];
            overflow    <= acc_next[CNT_W];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
`timescale 1ns/1ps
module tb_ro_freq_meter;

  localparam int SET = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  logic [15:0] win_len, win8;
  logic        ro_in, ro8;
  logic        ro_activate, busy, done, overflow;
  logic [15:0] count;
  logic        act8, busy8, done8, ovf8;
  logic [7:0]  count8;

  int     n_err = 0;
  int     n_chk = 0;
  bit     chk_en = 0;
  bit     osc_en = 1;
  int     edge_n = 0;
  longint ro_edges = 0;
  bit     m_active = 0;
  int     m_s = 0;
  int     m_w = 0;
  longint m_snap = 0;
  longint m_hold = 0;
  longint m_ovf = 0;

  ro_freq_meter #(.CNT_W(16), .WIN_W(16), .DELTA_W(6), .SYNC_STAGES(2), .SETTLE_CYC(SET)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .ro_in(ro_in),
    .ro_activate(ro_activate), .busy(busy), .done(done), .count(count), .overflow(overflow));

  ro_freq_meter #(.CNT_W(8), .WIN_W(16), .DELTA_W(6), .SYNC_STAGES(2), .SETTLE_CYC(SET)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .win_len(win8), .ro_in(ro8),
    .ro_activate(act8), .busy(busy8), .done(done8), .count(count8), .overflow(ovf8));

  always #5 clk = ~clk;

  // Oscillator models: 4 ns period, phase offset so edges never meet clk edges.
  initial begin
    ro_in = 1'b0;
    #0.3;
    forever begin
      #2;
      if (ro_activate && osc_en) ro_in = ~ro_in;
      else ro_in = 1'b0;
    end
  end

  initial begin
    ro8 = 1'b0;
    #0.3;
    forever begin
      #2;
      if (act8 && osc_en) ro8 = ~ro8;
      else ro8 = 1'b0;
    end
  end

  always @(posedge ro_in) ro_edges++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
    end
  endtask

  // Count may differ from the ideal-window count by one edge, modulo 2^16.
  task automatic chk_tol(input string nm, input longint act, input longint exp);
    longint d;
    n_chk++;
    d = (act - exp) & 64'hFFFF;
    if (!(d == 0 || d == 1 || d == 64'hFFFF)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d+-1 (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // What count/overflow must read for a given number of edges in the window.
  function automatic void set_model(input longint e);
`ifdef RO_FREQ_SAT_EN
    m_hold = (e > 65535) ? 65535 : e;
    m_ovf  = (e > 65535) ? 1 : 0;
`else
    m_hold = e % 65536;
    m_ovf  = 0;
`endif
  endfunction

  // Schedule model: window edges counted between entry to MEASURE and to DONE.
  always @(posedge clk) begin : model_p
    int c;
    edge_n++;
    if (m_active) begin
      c = edge_n - m_s;
      if (c == SET + 1) m_snap = ro_edges;
      if (c == SET + m_w + 1) set_model(ro_edges - m_snap);
    end
  end

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin : cmp_p
    int  c;
    bit  eb, ed;
    if (chk_en) begin
      if (rst_n) begin
        chk("rst_busy", busy, 0);
        chk("rst_ro_activate", ro_activate, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
      end else begin
        c  = edge_n - m_s;
        eb = m_active && c >= 1 && c <= SET + m_w;
        ed = m_active && c == SET + m_w + 1;
        chk("busy", busy, eb);
        chk("ro_activate", ro_activate, eb);
        chk("done", done, ed);
        chk_tol("count", count, m_hold);
        chk("overflow", overflow, m_ovf);
      end
    end
  end

  task automatic do_start(input int w);
    int c;
    @(negedge clk); #1;
    c = edge_n - m_s;
    start   = 1'b1;
    win_len = 16'(w);
    if (!m_active || c >= SET + m_w + 2) begin
      m_active = 1;
      m_s      = edge_n;
      m_w      = w;
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc, input longint lo, input longint hi);
    int s;
    bit seen;
    s    = m_s;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk); #2;
      if (done) begin
        seen = 1;
        chk({nm, "_cycle"}, edge_n - s, exp_cyc);
        chk_rng({nm, "_count"}, count, lo, hi);
        chk({nm, "_overflow"}, overflow, 0);
      end
    end
    chk({nm, "_done_seen"}, seen, 1);
  endtask

  initial begin : stim
    int s8, ndone, s;
    bit seen;
    start = 0; start8 = 0; win_len = 0; win8 = 0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("reset_ro_activate", ro_activate, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", count, 0);
    chk("reset_overflow", overflow, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    chk_en = 1;

    // Nominal 100-cycle window.
    do_start(100);
    wait_done("nominal", 105, 249, 251);

    // Zero-length window.
    do_start(0);
    wait_done("zero_win", 5, 0, 0);

    // Single-cycle window: 10 ns at 4 ns period.
    do_start(1);
    wait_done("win1", 6, 2, 3);

    // Oscillator stopped.
    osc_en = 0;
    do_start(50);
    wait_done("stopped", 55, 0, 0);
    osc_en = 1;

    // Second start at cycle 50 must be ignored.
    do_start(100);
    s = m_s;
    repeat (48) @(negedge clk);
    do_start(7);
    ndone = 0;
    while (edge_n - s < 130) begin
      @(negedge clk); #2;
      if (done) begin
        ndone++;
        chk("busy_start_cycle", edge_n - s, 105);
        chk_rng("busy_start_count", count, 249, 251);
      end
    end
    chk("busy_start_ndone", ndone, 1);

    // Saturation / wrap on the 8-bit instance.
    @(negedge clk); #1;
    start8 = 1'b1; win8 = 16'd200; s8 = edge_n;
    @(negedge clk); #1 start8 = 1'b0;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk); #2;
      if (done8) begin
        seen = 1;
        chk("sat_cycle", edge_n - s8, 205);
`ifdef RO_FREQ_SAT_EN
        chk("sat_count", count8, 255);
        chk("sat_overflow", ovf8, 1);
`else
        chk_rng("wrap_count", count8, 243, 245);
        chk("wrap_overflow", ovf8, 0);
`endif
      end
    end
    chk("sat_done_seen", seen, 1);

    // Reset in the middle of a measurement.
    do_start(100);
    repeat (58) @(negedge clk);
    @(negedge clk); #2;
    rst_n    = 1'b1;
    m_active = 0;
    m_hold   = 0;
    m_ovf    = 0;
    #1;
    chk("midrst_ro_activate", ro_activate, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", count, 0);
    chk("midrst_overflow", overflow, 0);
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Fresh measurement after reset.
    do_start(100);
    wait_done("after_rst", 105, 249, 251);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
